// File: rtl/m6800_pkg.sv
// Shared constants, register offsets and state encoding for the 6800-style bus target.
package m6800_pkg;

   localparam int unsigned E_PERIOD = 10;
   localparam int unsigned ADDR_W   = 16;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned CNT_W    = 16;
   localparam int unsigned RS_W     = 4;

   localparam logic [RS_W-1:0] RS_TA_LO = 4'd4;
   localparam logic [RS_W-1:0] RS_TA_HI = 4'd5;
   localparam logic [RS_W-1:0] RS_CTRL  = 4'd6;
   localparam logic [RS_W-1:0] RS_ICR   = 4'd7;

   localparam int unsigned CTRL_START   = 0;
   localparam int unsigned CTRL_ONESHOT = 1;
   localparam int unsigned CTRL_LOAD    = 4;
   localparam int unsigned ICR_TA       = 0;
   localparam int unsigned ICR_IR       = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEL  = 2'd1,
      ACT  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/m6800_resp_timer.sv
// 16-bit E-clocked down-timer: reload latch, counter, START/ONESHOT control and underflow flag.
module m6800_resp_timer
   import m6800_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              wr_lo,
   input  logic              wr_hi,
   input  logic              wr_ctrl,
   input  logic              clr_flag,
   input  logic [DATA_W-1:0] din,
   output logic [CNT_W-1:0]  cnt,
   output logic              start,
   output logic              oneshot,
   output logic              flag
);

   logic [CNT_W-1:0] latch_q, latch_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             start_q, start_d;
   logic             oneshot_q, oneshot_d;
   logic             flag_q, flag_d;
   logic             load;
   logic             underflow;

   // A load always beats a tick; a CTRL write always has the last word on START.
   always_comb begin
      latch_d   = latch_q;
      cnt_d     = cnt_q;
      start_d   = start_q;
      oneshot_d = oneshot_q;
      flag_d    = flag_q;
      underflow = 1'b0;
      load      = (wr_hi && !start_q) || (wr_ctrl && din[CTRL_LOAD]);

      if (wr_lo) latch_d[7:0]  = din;
      if (wr_hi) latch_d[15:8] = din;

      if (load) begin
         cnt_d = latch_d;
      end else if (tick && start_q) begin
         if (cnt_q == '0) begin
            cnt_d     = latch_d;
            underflow = 1'b1;
            if (oneshot_q) start_d = 1'b0;
         end else begin
            cnt_d = cnt_q - 16'd1;
         end
      end

      if (wr_ctrl) begin
         start_d   = din[CTRL_START];
         oneshot_d = din[CTRL_ONESHOT];
      end

      if (underflow)     flag_d = 1'b1;
      else if (clr_flag) flag_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         latch_q   <= '0;
         cnt_q     <= '0;
         start_q   <= 1'b0;
         oneshot_q <= 1'b0;
         flag_q    <= 1'b0;
      end else begin
         latch_q   <= latch_d;
         cnt_q     <= cnt_d;
         start_q   <= start_d;
         oneshot_q <= oneshot_d;
         flag_q    <= flag_d;
      end
   end

   assign cnt     = cnt_q;
   assign start   = start_q;
   assign oneshot = oneshot_q;
   assign flag    = flag_q;

endmodule

// File: rtl/m6800_responder.sv
// Peripheral end of the emulated 6800 cycle: VPA request, E-synchronous transfer, regs + timer.
// Optional interrupt output and ICR mask enabled by defining M6800_RESP_IRQ_EN.
module m6800_responder
   import m6800_pkg::*;
#(
   parameter logic [11:0] BASE_ADDR = 12'hBFE
)
(
   input  logic              C7M,
   input  logic              RESET,
   input  logic              AS_n,
   input  logic              RW,
   input  logic [ADDR_W-1:0] A,
   input  logic              E,
   input  logic              VMA_n,
   input  logic [DATA_W-1:0] DIN,
   output logic [DATA_W-1:0] DOUT,
   output logic              DOE,
   output logic              VPA_n
`ifdef M6800_RESP_IRQ_EN
   ,
   output logic              INT_n
`endif
);

   state_e              state_q, state_d;
   logic                e_q, e_d;
   logic                armed_q, armed_d;
   logic                vpa_n_q, vpa_n_d;
   logic                doe_q, doe_d;
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic [3:0][DATA_W-1:0] scratch_q, scratch_d;
   logic                mask_q, mask_d;
   logic                int_n_q, int_n_d;

   logic                e_rise, e_fall, match, commit, wr, rd_icr;
   logic [RS_W-1:0]     rs;
   logic [DATA_W-1:0]   rd_data, ctrl_rd, icr_rd;
   logic [CNT_W-1:0]    t_cnt;
   logic                t_start, t_oneshot, t_flag;

   assign e_rise = E & ~e_q;
   assign e_fall = ~E & e_q;
   assign match  = (A[ADDR_W-1:RS_W] == BASE_ADDR);
   assign rs     = A[RS_W-1:0];
   assign wr     = commit & ~RW;
   assign rd_icr = commit & RW & (rs == RS_ICR);

   m6800_resp_timer u_timer (
      .clk      (C7M),
      .rst      (RESET),
      .tick     (e_fall),
      .wr_lo    (wr && (rs == RS_TA_LO)),
      .wr_hi    (wr && (rs == RS_TA_HI)),
      .wr_ctrl  (wr && (rs == RS_CTRL)),
      .clr_flag (rd_icr),
      .din      (DIN),
      .cnt      (t_cnt),
      .start    (t_start),
      .oneshot  (t_oneshot),
      .flag     (t_flag)
   );

   // Read mux; the timer registers always reflect the live counter.
   always_comb begin
      ctrl_rd               = '0;
      ctrl_rd[CTRL_START]   = t_start;
      ctrl_rd[CTRL_ONESHOT] = t_oneshot;
      icr_rd                = '0;
      icr_rd[ICR_TA]        = t_flag;
      icr_rd[ICR_IR]        = t_flag & mask_q;
      rd_data               = '0;
      case (rs)
         4'd0, 4'd1, 4'd2, 4'd3: rd_data = scratch_q[rs[1:0]];
         RS_TA_LO:               rd_data = t_cnt[7:0];
         RS_TA_HI:               rd_data = t_cnt[15:8];
         RS_CTRL:                rd_data = ctrl_rd;
         RS_ICR:                 rd_data = icr_rd;
         default:                rd_data = '0;
      endcase
   end

   // Bus cycle sequencing; a fresh AS_n high must be seen before a new select.
   always_comb begin
      state_d   = state_q;
      e_d       = E;
      armed_d   = armed_q | AS_n;
      vpa_n_d   = vpa_n_q;
      doe_d     = doe_q;
      dout_d    = dout_q;
      scratch_d = scratch_q;
      mask_d    = mask_q;
      commit    = 1'b0;

      if (state_q != IDLE && AS_n) begin
         state_d = IDLE;
         vpa_n_d = 1'b1;
         doe_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (!AS_n && match && armed_q) begin
               state_d = SEL;
               vpa_n_d = 1'b0;
               armed_d = 1'b0;
            end
            SEL: if (!VMA_n && e_rise) begin
               state_d = ACT;
               if (RW) begin
                  dout_d = rd_data;
                  doe_d  = 1'b1;
               end
            end
            ACT: if (e_fall) begin
               state_d = DONE;
               commit  = 1'b1;
            end
            default: ;
         endcase
      end

      if (wr && (rs[3:2] == 2'b00)) scratch_d[rs[1:0]] = DIN;
`ifdef M6800_RESP_IRQ_EN
      if (wr && (rs == RS_ICR) && DIN[0]) mask_d = DIN[7];
`endif
      int_n_d = ~(t_flag & mask_q);
   end

   always_ff @(posedge C7M) begin
      if (RESET) begin
         state_q   <= IDLE;
         e_q       <= 1'b0;
         armed_q   <= 1'b0;
         vpa_n_q   <= 1'b1;
         doe_q     <= 1'b0;
         dout_q    <= '0;
         scratch_q <= '0;
         mask_q    <= 1'b0;
         int_n_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         e_q       <= e_d;
         armed_q   <= armed_d;
         vpa_n_q   <= vpa_n_d;
         doe_q     <= doe_d;
         dout_q    <= dout_d;
         scratch_q <= scratch_d;
         mask_q    <= mask_d;
         int_n_q   <= int_n_d;
      end
   end

   assign DOUT  = dout_q;
   assign DOE   = doe_q;
   assign VPA_n = vpa_n_q;
`ifdef M6800_RESP_IRQ_EN
   assign INT_n = int_n_q;
`endif

endmodule
